// File: rtl/top_multiplier.sv
// Signed 16x16 -> 32-bit multiplier: radix-4 Booth recoding, carry-save reduction tree and a
// Kogge-Stone final adder. The product is combinational; a registered copy is also provided.
module top_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic [31:0] result_out,
  output logic [31:0] result_reg_out
);

  localparam int unsigned NumPp = 8;
  localparam int unsigned PpW   = 17;
  localparam int unsigned ProdW = 32;

  // ---------------------------------------------------------------------------------------------
  // Carry-save helpers
  // ---------------------------------------------------------------------------------------------
  function automatic logic [ProdW-1:0] maj3(input logic [ProdW-1:0] a,
                                            input logic [ProdW-1:0] b,
                                            input logic [ProdW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // 3:2 counter; returns {carry, sum} with the carry already weighted by one bit position.
  function automatic logic [2*ProdW-1:0] csa32(input logic [ProdW-1:0] a,
                                               input logic [ProdW-1:0] b,
                                               input logic [ProdW-1:0] c);
    logic [ProdW-1:0] s;
    logic [ProdW-1:0] cy;
    s  = a ^ b ^ c;
    cy = maj3(a, b, c) << 1;
    return {cy, s};
  endfunction

  // 4:2 compressor built from two chained 3:2 counters; returns {carry, sum}.
  function automatic logic [2*ProdW-1:0] comp42(input logic [ProdW-1:0] a,
                                                input logic [ProdW-1:0] b,
                                                input logic [ProdW-1:0] c,
                                                input logic [ProdW-1:0] d);
    logic [2*ProdW-1:0] first;
    first = csa32(a, b, c);
    return csa32(first[ProdW-1:0], first[2*ProdW-1:ProdW], d);
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Booth recoding and partial product generation
  // ---------------------------------------------------------------------------------------------
  logic [16:0]      y_ext;
  logic [PpW-1:0]   x_one;
  logic [PpW-1:0]   x_two;
  logic [ProdW-1:0] pp_row [NumPp];
  logic [ProdW-1:0] corr_row;
  logic [NumPp-1:0] dig_neg;
  logic [NumPp-1:0] dig_one;
  logic [NumPp-1:0] dig_two;

  assign y_ext = {y_in, 1'b0};
  // 17-bit operand images keep x_in = 0x8000 times +/-2 exact.
  assign x_one = {x_in[15], x_in};
  assign x_two = {x_in, 1'b0};

  always_comb begin
    corr_row = '0;
    dig_neg  = '0;
    dig_one  = '0;
    dig_two  = '0;
    for (int i = 0; i < NumPp; i++) begin
      logic [2:0]     trip;
      logic [PpW-1:0] mag;
      logic [PpW-1:0] pp;
      trip       = y_ext[2*i +: 3];
      dig_neg[i] = trip[2];
      dig_one[i] = trip[1] ^ trip[0];
      dig_two[i] = (trip == 3'b011) || (trip == 3'b100);
      if (dig_one[i]) begin
        mag = x_one;
      end else if (dig_two[i]) begin
        mag = x_two;
      end else begin
        mag = '0;
      end
      // Negative digits take the one's complement; the +1 lands in corr_row at bit 2i.
      pp          = dig_neg[i] ? ~mag : mag;
      pp_row[i]   = {{(ProdW - PpW){pp[PpW-1]}}, pp} << (2 * i);
      corr_row[2*i] = dig_neg[i];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Reduction tree: 9 rows -> 5 -> 3 -> 2
  // ---------------------------------------------------------------------------------------------
  logic [2*ProdW-1:0] lvl1_a;
  logic [2*ProdW-1:0] lvl1_b;
  logic [2*ProdW-1:0] lvl2;
  logic [2*ProdW-1:0] lvl3;
  logic [ProdW-1:0]   sum_row;
  logic [ProdW-1:0]   carry_row;

  always_comb begin
    lvl1_a    = comp42(pp_row[0], pp_row[1], pp_row[2], pp_row[3]);
    lvl1_b    = comp42(pp_row[4], pp_row[5], pp_row[6], pp_row[7]);
    lvl2      = comp42(lvl1_a[ProdW-1:0], lvl1_a[2*ProdW-1:ProdW],
                       lvl1_b[ProdW-1:0], lvl1_b[2*ProdW-1:ProdW]);
    lvl3      = csa32(lvl2[ProdW-1:0], lvl2[2*ProdW-1:ProdW], corr_row);
    sum_row   = lvl3[ProdW-1:0];
    carry_row = lvl3[2*ProdW-1:ProdW];
  end

  // ---------------------------------------------------------------------------------------------
  // Final carry-propagate adder (Kogge-Stone prefix); carry out of bit 31 is dropped.
  // ---------------------------------------------------------------------------------------------
  logic [ProdW-1:0] cpa_p0;
  logic [ProdW-1:0] cpa_g;
  logic [ProdW-1:0] cpa_p;
  logic [ProdW-1:0] cpa_carry;

  always_comb begin
    cpa_p0 = sum_row ^ carry_row;
    cpa_g  = sum_row & carry_row;
    cpa_p  = cpa_p0;
    for (int l = 0; l < 5; l++) begin
      logic [ProdW-1:0] g_nxt;
      logic [ProdW-1:0] p_nxt;
      g_nxt = cpa_g;
      p_nxt = cpa_p;
      for (int k = 0; k < ProdW; k++) begin
        if (k >= (1 << l)) begin
          g_nxt[k] = cpa_g[k] | (cpa_p[k] & cpa_g[k - (1 << l)]);
          p_nxt[k] = cpa_p[k] & cpa_p[k - (1 << l)];
        end
      end
      cpa_g = g_nxt;
      cpa_p = p_nxt;
    end
    cpa_carry  = {cpa_g[ProdW-2:0], 1'b0};
    result_out = cpa_p0 ^ cpa_carry;
  end

  // ---------------------------------------------------------------------------------------------
  // Registered product
  // ---------------------------------------------------------------------------------------------
  logic [ProdW-1:0] result_reg_d;
  logic [ProdW-1:0] result_reg_q;

  always_comb begin
    result_reg_d = result_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg_q <= '0;
    end else begin
      result_reg_q <= result_reg_d;
    end
  end

  assign result_reg_out = result_reg_q;

endmodule

// File: tb/tb_top_multiplier.sv
// Self-checking bench for top_multiplier: directed corners, random operands against an
// arithmetic reference, and asynchronous reset behaviour of the registered product.
module tb_top_multiplier;

  logic        clk;
  logic        rst_n;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [31:0] result_out;
  logic [31:0] result_reg_out;

  int unsigned n_vec;
  int unsigned n_err;

  top_multiplier dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .x_in           (x_in),
    .y_in           (y_in),
    .result_out     (result_out),
    .result_reg_out (result_reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed integer multiplication.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int xs;
    int ys;
    xs = int'($signed(x));
    ys = int'($signed(y));
    return 32'(xs * ys);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    x_in  = 16'h0005;
    y_in  = 16'h0007;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (result_reg_out !== 32'h0) begin
        n_err++;
        $display("FAIL reset_reg cyc=%0d got=%08h want=00000000", c, result_reg_out);
      end
      n_vec++;
      if (result_out !== 32'h0000_0023) begin
        n_err++;
        $display("FAIL reset_comb cyc=%0d got=%08h want=00000023", c, result_out);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (result_reg_out !== 32'h0000_0023) begin
      n_err++;
      $display("FAIL reset_first_load got=%08h want=00000023", result_reg_out);
    end
  endtask

  task automatic test_corners();
    logic [15:0] xs [8];
    logic [15:0] ys [8];
    logic [31:0] ws [8];
    xs = '{16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF, 16'h0003, 16'h1234, 16'h8000, 16'hC000};
    ys = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFE, 16'h0000, 16'h0004, 16'h000C};
    ws = '{32'h3FFF_0001, 32'h4000_0000, 32'hC000_8000, 32'h0000_0001,
           32'hFFFF_FFFA, 32'h0000_0000, 32'hFFFE_0000, 32'hFFFD_0000};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      x_in = xs[i];
      y_in = ys[i];
      #2;
      n_vec++;
      if (result_out !== ws[i]) begin
        n_err++;
        $display("FAIL corner_%0d x=%04h y=%04h got=%08h want=%08h",
                 i, xs[i], ys[i], result_out, ws[i]);
      end
    end
  endtask

  // One new pair per clock: combinational check before the edge, registered check after it.
  task automatic test_random(input int unsigned count, input bit biased);
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] want;
    logic [15:0] picks [4];
    picks = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    for (int n = 0; n < count; n++) begin
      x = 16'($urandom % 32'h10000);
      y = 16'($urandom % 32'h10000);
      if (biased && ($urandom_range(0, 1) == 0)) x = picks[$urandom_range(0, 3)];
      if (biased && ($urandom_range(0, 1) == 0)) y = picks[$urandom_range(0, 3)];
      want = ref_mul(x, y);
      @(negedge clk);
      x_in = x;
      y_in = y;
      #4;
      n_vec++;
      if (result_out !== want) begin
        n_err++;
        $display("FAIL random_comb x=%04h y=%04h got=%08h want=%08h", x, y, result_out, want);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (result_reg_out !== want) begin
        n_err++;
        $display("FAIL random_reg x=%04h y=%04h got=%08h want=%08h",
                 x, y, result_reg_out, want);
      end
    end
  endtask

  task automatic test_async_reset();
    time t_drop;
    @(negedge clk);
    x_in = 16'h7FFF;
    y_in = 16'h7FFF;
    @(posedge clk);
    #1;
    n_vec++;
    if (result_reg_out !== 32'h3FFF_0001) begin
      n_err++;
      $display("FAIL async_preload got=%08h want=3FFF0001", result_reg_out);
    end
    @(negedge clk);
    #2;
    t_drop = $time;
    rst_n  = 1'b0;
    #1;
    n_vec++;
    if (result_reg_out !== 32'h0) begin
      n_err++;
      $display("FAIL async_clear got=%08h want=00000000 dt=%0t", result_reg_out, $time - t_drop);
    end
    x_in = 16'hFFFF;
    y_in = 16'h0002;
    #1;
    n_vec++;
    if (result_out !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL async_comb_tracks got=%08h want=FFFFFFFE", result_out);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (result_reg_out !== 32'h0) begin
      n_err++;
      $display("FAIL async_hold got=%08h want=00000000", result_reg_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (result_reg_out !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL async_release got=%08h want=FFFFFFFE", result_reg_out);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    x_in  = 16'h0;
    y_in  = 16'h0;
    test_reset();
    test_corners();
    test_random(100, 1'b0);
    test_random(200, 1'b1);
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
